// File: rtl/mem_burst_reader_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_burst_reader_if                                              |
// | Memory read port and streaming output bundle for the reader.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface mem_burst_reader_if #(
  parameter int DW = 13,
  parameter int AW = 6
);
  logic          mem_w_rb;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_last;

  modport master (
    output mem_w_rb, mem_addr, dout, dout_valid, dout_last,
    input  mem_rdata, dout_ready
  );

  modport slave (
    input  mem_w_rb, mem_addr, dout, dout_valid, dout_last,
    output mem_rdata, dout_ready
  );
endinterface
`default_nettype wire

// File: rtl/mem_burst_reader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_burst_reader                                                 |
// | Walks a burst of memory addresses and streams words with a sum.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mem_burst_reader #(
  parameter int DW = 13,
  parameter int AW = 6,
  parameter int CW = 16
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic          start,
  input  wire logic [AW-1:0] base_addr,
  input  wire logic [AW-1:0] len,
  input  wire logic          abort,
  output logic               busy,
  output logic               done,
  output logic [CW-1:0]      checksum,
  mem_burst_reader_if.master m
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [AW:0] C_FULL_LEN = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] C_REM_ONE  = {{AW{1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [AW:0]   remaining_q, remaining_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          dout_last_q, dout_last_d;
  logic [CW-1:0] checksum_q, checksum_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      mem_addr_q   <= '0;
      remaining_q  <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      checksum_q   <= '0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      remaining_q  <= remaining_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      checksum_q   <= checksum_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    remaining_d  = remaining_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    checksum_d   = checksum_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          mem_addr_d  = base_addr;
          remaining_d = (len == '0) ? C_FULL_LEN : {1'b0, len};
          checksum_d  = '0;
          state_d     = S_READ;
        end
      end
      S_READ: begin
        if (abort) begin
          dout_valid_d = 1'b0;
          dout_last_d  = 1'b0;
          state_d      = S_IDLE;
        end else begin
          dout_d       = m.mem_rdata;
          dout_valid_d = 1'b1;
          dout_last_d  = (remaining_q == C_REM_ONE);
          state_d      = S_SEND;
        end
      end
      S_SEND: begin
        // Abort takes priority: a word handed over in the abort cycle is discarded.
        if (abort) begin
          dout_valid_d = 1'b0;
          dout_last_d  = 1'b0;
          state_d      = S_IDLE;
        end else if (m.dout_ready) begin
          checksum_d   = checksum_q + {{(CW-DW){1'b0}}, dout_q};
          dout_valid_d = 1'b0;
          dout_last_d  = 1'b0;
          if (dout_last_q) begin
            state_d = S_DONE;
          end else begin
            mem_addr_d  = mem_addr_q + {{(AW-1){1'b0}}, 1'b1};
            remaining_d = remaining_q - C_REM_ONE;
            state_d     = S_READ;
          end
        end
      end
      default: begin
        dout_valid_d = 1'b0;
        state_d      = S_IDLE;
      end
    endcase
  end

  assign m.mem_w_rb   = 1'b0;
  assign m.mem_addr   = mem_addr_q;
  assign m.dout       = dout_q;
  assign m.dout_valid = dout_valid_q;
  assign m.dout_last  = dout_last_q;
  assign busy         = (state_q == S_READ) || (state_q == S_SEND);
  assign done         = (state_q == S_DONE);
  assign checksum     = checksum_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_reader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_burst_reader                                              |
// | Directed self-checking bench for mem_burst_reader.               |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_mem_burst_reader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [5:0]  base_addr;
  logic [5:0]  len;
  logic        abort;
  logic        busy;
  logic        done;
  logic [15:0] checksum;

  logic [12:0] mem [64];

  int n_vec = 0;
  int n_err = 0;

  logic [12:0] got_w [$];
  logic        got_l [$];
  int          done_cyc, last_cyc;
  bit          done_seen, stable_bad, wrb_bad, busy_at_done;
  int          stall_idx, stall_n;

  mem_burst_reader_if #(.DW(13), .AW(6)) mif ();

  assign mif.mem_rdata = mem[mif.mem_addr];

  mem_burst_reader #(.DW(13), .AW(6), .CW(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum),
    .m         (mif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic load_ramp();
    for (int i = 0; i < 64; i++) mem[i] = 13'(i + 100);
  endtask

  // Runs the sink until done or budget; optionally stalls on word stall_idx.
  task automatic collect(input int budget);
    logic [12:0] snap_d;
    logic        snap_l;
    int          stall_cnt;
    got_w.delete();
    got_l.delete();
    done_seen = 0; stable_bad = 0; wrb_bad = 0; busy_at_done = 0;
    done_cyc = -1; last_cyc = -1; stall_cnt = 0;
    snap_d = '0; snap_l = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (mif.mem_w_rb !== 1'b0) wrb_bad = 1;
      if (done === 1'b1) begin
        done_seen = 1; done_cyc = c; busy_at_done = busy;
        break;
      end
      if (mif.dout_valid === 1'b1) begin
        if (stall_cnt < stall_n && got_w.size() == stall_idx) begin
          if (stall_cnt == 0) begin
            snap_d = mif.dout; snap_l = mif.dout_last;
          end else if (mif.dout !== snap_d || mif.dout_last !== snap_l) begin
            stable_bad = 1;
          end
          mif.dout_ready = 1'b0;
          stall_cnt++;
        end else begin
          if (stall_n > 0 && got_w.size() == stall_idx &&
              (mif.dout !== snap_d || mif.dout_last !== snap_l)) stable_bad = 1;
          mif.dout_ready = 1'b1;
          got_w.push_back(mif.dout);
          got_l.push_back(mif.dout_last);
          if (mif.dout_last === 1'b1) last_cyc = c;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 0; abort = 0; base_addr = 0; len = 0;
    mif.dout_ready = 1'b1;
    #12;
    n_vec++;
    if ({mif.dout_valid, mif.dout_last, busy, done, mif.mem_w_rb} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b expected 00000",
               {mif.dout_valid, mif.dout_last, busy, done, mif.mem_w_rb});
    end
    n_vec++;
    if (mif.dout !== 13'd0 || checksum !== 16'd0 || mif.mem_addr !== 6'd0) begin
      n_err++;
      $display("FAIL reset_data: got dout=%0d cs=%0d addr=%0d expected 0/0/0",
               mif.dout, checksum, mif.mem_addr);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    load_ramp();
    stall_n = 0; stall_idx = 0;
    base_addr = 6'd5; len = 6'd3; start = 1'b1; mif.dout_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || mif.dout_valid !== 1'b0 || mif.mem_addr !== 6'd5) begin
      n_err++;
      $display("FAIL basic_edge1: got busy=%b valid=%b addr=%0d expected 1/0/5",
               busy, mif.dout_valid, mif.mem_addr);
    end
    @(negedge clk);
    n_vec++;
    if (mif.dout_valid !== 1'b1 || mif.dout !== 13'd105 || mif.dout_last !== 1'b0) begin
      n_err++;
      $display("FAIL basic_latency: got valid=%b dout=%0d last=%b expected 1/105/0",
               mif.dout_valid, mif.dout, mif.dout_last);
    end
    collect(40);
    n_vec++;
    if (got_w.size() != 3 || got_w[0] !== 13'd105 || got_w[1] !== 13'd106 ||
        got_w[2] !== 13'd107) begin
      n_err++;
      $display("FAIL basic_words: got n=%0d expected 105,106,107", got_w.size());
    end
    n_vec++;
    if (got_w.size() != 3 || got_l[0] !== 1'b0 || got_l[1] !== 1'b0 || got_l[2] !== 1'b1) begin
      n_err++;
      $display("FAIL basic_last: got n=%0d expected last only on word 3", got_w.size());
    end
    n_vec++;
    if (!done_seen || done_cyc != last_cyc + 1 || busy_at_done !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done: got seen=%0d done_cyc=%0d last_cyc=%0d busy=%b expected done 1 cycle after last, busy 0",
               done_seen, done_cyc, last_cyc, busy_at_done);
    end
    n_vec++;
    if (checksum !== 16'd318) begin
      n_err++;
      $display("FAIL basic_checksum: got %0d expected 318", checksum);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0 || mif.mem_addr !== 6'd7) begin
      n_err++;
      $display("FAIL basic_after: got done=%b busy=%b addr=%0d expected 0/0/7",
               done, busy, mif.mem_addr);
    end
  endtask

  task automatic test_wrap();
    load_ramp();
    stall_n = 0;
    base_addr = 6'd62; len = 6'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect(40);
    n_vec++;
    if (got_w.size() != 4 || got_w[0] !== 13'd162 || got_w[1] !== 13'd163 ||
        got_w[2] !== 13'd100 || got_w[3] !== 13'd101) begin
      n_err++;
      $display("FAIL wrap_words: got n=%0d expected 162,163,100,101", got_w.size());
    end
    n_vec++;
    if (got_w.size() != 4 || got_l[2] !== 1'b0 || got_l[3] !== 1'b1 || !done_seen) begin
      n_err++;
      $display("FAIL wrap_last: got n=%0d done=%0d expected last on word 4 and done",
               got_w.size(), done_seen);
    end
    n_vec++;
    if (checksum !== 16'd526) begin
      n_err++;
      $display("FAIL wrap_checksum: got %0d expected 526", checksum);
    end
    @(negedge clk);
  endtask

  task automatic test_full_len();
    int bad;
    for (int i = 0; i < 64; i++) mem[i] = 13'd1;
    stall_n = 0;
    base_addr = 6'd17; len = 6'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect(300);
    bad = 0;
    foreach (got_w[i]) if (got_w[i] !== 13'd1 || got_l[i] !== (i == 63)) bad++;
    n_vec++;
    if (got_w.size() != 64 || bad != 0 || !done_seen) begin
      n_err++;
      $display("FAIL full_words: got n=%0d bad=%0d done=%0d expected 64 ones, last on 64th, done",
               got_w.size(), bad, done_seen);
    end
    n_vec++;
    if (checksum !== 16'd64) begin
      n_err++;
      $display("FAIL full_checksum: got %0d expected 64", checksum);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    load_ramp();
    stall_n = 5; stall_idx = 1;
    base_addr = 6'd10; len = 6'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect(60);
    stall_n = 0;
    n_vec++;
    if (got_w.size() != 4 || got_w[0] !== 13'd110 || got_w[1] !== 13'd111 ||
        got_w[2] !== 13'd112 || got_w[3] !== 13'd113) begin
      n_err++;
      $display("FAIL bp_words: got n=%0d expected 110..113", got_w.size());
    end
    n_vec++;
    if (stable_bad || wrb_bad || !done_seen) begin
      n_err++;
      $display("FAIL bp_stable: got unstable=%0d wrb=%0d done=%0d expected 0/0/1",
               stable_bad, wrb_bad, done_seen);
    end
    n_vec++;
    if (checksum !== 16'd446) begin
      n_err++;
      $display("FAIL bp_checksum: got %0d expected 446", checksum);
    end
    mif.dout_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_abort();
    load_ramp();
    // start and abort together in IDLE must not launch a burst
    base_addr = 6'd30; len = 6'd2; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || mif.mem_addr === 6'd30) begin
      n_err++;
      $display("FAIL abort_idle: got busy=%b addr=%0d expected idle, addr not 30",
               busy, mif.mem_addr);
    end
    base_addr = 6'd20; len = 6'd4; start = 1'b1; mif.dout_ready = 1'b1;
    @(negedge clk);
    base_addr = 6'd40; len = 6'd1;
    @(negedge clk);
    mif.dout_ready = 1'b1;
    @(negedge clk);
    mif.dout_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (mif.dout_valid !== 1'b1 || mif.dout !== 13'd121 || mif.mem_addr !== 6'd21) begin
      n_err++;
      $display("FAIL abort_word2: got valid=%b dout=%0d addr=%0d expected 1/121/21",
               mif.dout_valid, mif.dout, mif.mem_addr);
    end
    abort = 1'b1; mif.dout_ready = 1'b1; start = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || mif.dout_valid !== 1'b0 || mif.dout_last !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL abort_state: got busy=%b valid=%b last=%b done=%b expected 0/0/0/0",
               busy, mif.dout_valid, mif.dout_last, done);
    end
    n_vec++;
    if (checksum !== 16'd120) begin
      n_err++;
      $display("FAIL abort_checksum: got %0d expected 120", checksum);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0 || mif.mem_addr !== 6'd21) begin
      n_err++;
      $display("FAIL abort_after: got done=%b busy=%b addr=%0d expected 0/0/21",
               done, busy, mif.mem_addr);
    end
  endtask

  task automatic test_async_reset();
    load_ramp();
    base_addr = 6'd0; len = 6'd8; start = 1'b1; mif.dout_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (mif.dout_valid !== 1'b1 || mif.dout !== 13'd101 || checksum !== 16'd100) begin
      n_err++;
      $display("FAIL areset_pre: got valid=%b dout=%0d cs=%0d expected 1/101/100",
               mif.dout_valid, mif.dout, checksum);
    end
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if ({mif.dout_valid, mif.dout_last, busy, done} !== 4'b0 || mif.dout !== 13'd0 ||
        checksum !== 16'd0 || mif.mem_addr !== 6'd0) begin
      n_err++;
      $display("FAIL areset_clear: got valid=%b busy=%b dout=%0d cs=%0d addr=%0d expected all 0",
               mif.dout_valid, busy, mif.dout, checksum, mif.mem_addr);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    base_addr = 6'd3; len = 6'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect(40);
    n_vec++;
    if (got_w.size() != 2 || got_w[0] !== 13'd103 || got_w[1] !== 13'd104 ||
        got_l[1] !== 1'b1 || !done_seen || checksum !== 16'd207) begin
      n_err++;
      $display("FAIL areset_rerun: got n=%0d done=%0d cs=%0d expected 103,104 cs=207",
               got_w.size(), done_seen, checksum);
    end
  endtask

  initial begin
    stall_n = 0; stall_idx = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_full_len();
    test_backpressure();
    test_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
